// File: rtl/wb_dbg_fanout.sv
// Wishbone slave that fans one host bus out to three debug cores, with a
// small local register bank (CTRL, STATUS, ID) and a per-access wait timeout.
module wb_dbg_fanout #(
  parameter logic [3:0] BASE_NIBBLE = 4'h3,
  parameter logic [7:0] TIMEOUT     = 8'd64
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [31:0] o_dbg_adr,
  output logic [31:0] o_dbg_dat,
  output logic [3:0]  o_dbg_sel,
  output logic        o_dbg_we,
  output logic [2:0]  o_dbg_stb,
  input  logic [95:0] i_dbg_rdt,
  input  logic [2:0]  i_dbg_ack,
  output logic [2:0]  o_debug_mode
);

  typedef enum logic [1:0] {S_IDLE, S_FWD, S_RESP} state_t;

  localparam logic [31:0] ID_VALUE   = 32'h53554233;
  localparam logic [31:0] TMO_VALUE  = 32'hDEADBEEF;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_tgt;
  logic [7:0]  r_cnt;
  logic [2:0]  r_stb;
  logic [31:0] r_dat_o;
  logic [31:0] r_adr;
  logic [31:0] r_dat;
  logic [3:0]  r_sel;
  logic        r_we;
  logic [2:0]  r_mode;
  logic [2:0]  r_err;

  logic        w_req;
  logic        w_local;
  logic        w_core_ack;
  logic        w_tmo;
  logic        w_lwr;
  logic [31:0] w_rdt_sel;
  logic [31:0] w_loc_rd;

  assign w_req      = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:28] == BASE_NIBBLE);
  assign w_local    = (wbs_adr_i[25:24] == 2'd3);
  assign w_lwr      = wbs_we_i & wbs_sel_i[0];
  // r_stb holds the one-hot target while forwarding, so it masks stray acks
  assign w_core_ack = |(i_dbg_ack & r_stb);
  assign w_tmo      = (r_cnt == (TIMEOUT - 8'd1));

  assign wbs_ack_o    = (r_state == S_RESP) & wbs_cyc_i;
  assign wbs_dat_o    = r_dat_o;
  assign o_dbg_adr    = r_adr;
  assign o_dbg_dat    = r_dat;
  assign o_dbg_sel    = r_sel;
  assign o_dbg_we     = r_we;
  assign o_dbg_stb    = r_stb;
  assign o_debug_mode = r_mode;

  // Select the acknowledging core's read-data slice
  always_comb begin
    w_rdt_sel = 32'h0;
    case (r_tgt)
      2'd0:    w_rdt_sel = i_dbg_rdt[31:0];
      2'd1:    w_rdt_sel = i_dbg_rdt[63:32];
      2'd2:    w_rdt_sel = i_dbg_rdt[95:64];
      default: w_rdt_sel = 32'h0;
    endcase
  end

  // Local register read mux, addressed straight from the host bus
  always_comb begin
    w_loc_rd = 32'h0;
    case (wbs_adr_i[3:2])
      2'd0:    w_loc_rd = {29'b0, r_mode};
      2'd1:    w_loc_rd = {29'b0, r_err};
      2'd2:    w_loc_rd = ID_VALUE;
      default: w_loc_rd = 32'h0;
    endcase
  end

  // State register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic; RESP always returns to IDLE so a held request re-arms
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_req) w_next = w_local ? S_RESP : S_FWD;
      S_FWD:   if (w_core_ack || w_tmo) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch, core strobe, wait counter and host read data
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_tgt   <= 2'd0;
      r_cnt   <= 8'd0;
      r_stb   <= 3'b000;
      r_dat_o <= 32'h0;
      r_adr   <= 32'h0;
      r_dat   <= 32'h0;
      r_sel   <= 4'h0;
      r_we    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_adr <= wbs_adr_i;
            r_dat <= wbs_dat_i;
            r_sel <= wbs_sel_i;
            r_we  <= wbs_we_i;
            r_tgt <= wbs_adr_i[25:24];
            r_cnt <= 8'd0;
            if (w_local) r_dat_o <= w_loc_rd;
            else         r_stb   <= 3'b001 << wbs_adr_i[25:24];
          end
        end
        S_FWD: begin
          if (w_core_ack) begin
            r_dat_o <= w_rdt_sel;
            r_stb   <= 3'b000;
          end else if (w_tmo) begin
            r_dat_o <= TMO_VALUE;
            r_stb   <= 3'b000;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // CTRL and STATUS registers: local writes plus timeout error capture
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_mode <= 3'b111;
      r_err  <= 3'b000;
    end else begin
      if (r_state == S_IDLE && w_req && w_local && w_lwr) begin
        if (wbs_adr_i[3:2] == 2'd0) r_mode <= wbs_dat_i[2:0];
        if (wbs_adr_i[3:2] == 2'd1) r_err  <= r_err & ~wbs_dat_i[2:0];
      end
      if (r_state == S_FWD && !w_core_ack && w_tmo) r_err <= r_err | r_stb;
    end
  end

endmodule
